// File: rtl/board_snapshot_loader.sv
// Double-buffered board snapshot: fetches NUM_CELLS words from data memory
// on each vsync fall, then commits them atomically to the display bank.
// Ports: clk, rst_n, vsync, load_en | mem_rd_en, mem_addr, mem_rd_data |
//        cell_sel, cell_state | busy, frame_done, bad_cell.
module board_snapshot_loader #(
  parameter logic [11:0] BASE_ADDR  = 12'd2048,
  parameter int          NUM_CELLS  = 42,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        load_en,
  output logic        mem_rd_en,
  output logic [11:0] mem_addr,
  input  logic [15:0] mem_rd_data,
  input  logic [5:0]  cell_sel,
  output logic [1:0]  cell_state,
  output logic        busy,
  output logic        frame_done,
  output logic        bad_cell
);

  localparam int KMAX = (NUM_CELLS > RD_LATENCY) ? NUM_CELLS : RD_LATENCY;
  localparam int KW   = $clog2(KMAX + 1);

  localparam logic [KW-1:0] K_LAST = KW'(NUM_CELLS - 1);
  localparam logic [KW-1:0] D_LAST = KW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [KW-1:0] k;
  logic          vsync_q;
  logic          armed;
  logic          trig;

  logic [RD_LATENCY-1:0] pv;
  logic [KW-1:0]         pk [RD_LATENCY];

  logic [1:0] shadow  [NUM_CELLS];
  logic [1:0] display [NUM_CELLS];

  logic       wr_en;
  logic [1:0] wr_val;
  logic       wr_bad;

  // armed only after a genuine high vsync sample, so a vsync held low
  // through reset release cannot look like a falling edge.
  assign trig = armed & vsync_q & ~vsync & load_en & (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (trig) state_nx = FETCH;
      FETCH:  if (k == K_LAST) state_nx = DRAIN;
      DRAIN:  if (k == D_LAST) state_nx = COMMIT;
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = BASE_ADDR;
    busy      = (state != IDLE);
    if (state == FETCH) begin
      mem_rd_en = 1'b1;
      mem_addr  = BASE_ADDR + 12'(k);
    end
  end

  // k doubles as the drain counter; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (state_nx != state) begin
      k <= '0;
    end else if (state == FETCH || state == DRAIN) begin
      k <= k + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      armed   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      armed   <= armed | vsync;
    end
  end

  // Tracks the cell index of each outstanding read until its data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pk[i] <= '0;
    end else begin
      pv[0] <= mem_rd_en;
      pk[0] <= k;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pk[i] <= pk[i-1];
      end
    end
  end

  assign wr_en = pv[RD_LATENCY-1];

  always_comb begin
    wr_val = 2'b11;
    wr_bad = 1'b1;
    unique case (mem_rd_data)
      16'd0: begin wr_val = 2'b00; wr_bad = 1'b0; end
      16'd1: begin wr_val = 2'b01; wr_bad = 1'b0; end
      16'd2: begin wr_val = 2'b10; wr_bad = 1'b0; end
      default: begin wr_val = 2'b11; wr_bad = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CELLS; i++) shadow[i] <= 2'b00;
    end else if (wr_en) begin
      shadow[pk[RD_LATENCY-1]] <= wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CELLS; i++) display[i] <= 2'b00;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_CELLS; i++) display[i] <= shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      bad_cell   <= 1'b0;
    end else begin
      frame_done <= (state == COMMIT);
      bad_cell   <= bad_cell | (wr_en & wr_bad);
    end
  end

  always_comb begin
    cell_state = 2'b00;
    if (cell_sel < 6'(NUM_CELLS)) cell_state = display[cell_sel];
  end

endmodule

// File: tb/tb_board_snapshot_loader.sv
// Bench for board_snapshot_loader: directed snapshots against a
// one-cycle-latency memory model with hand-computed expectations.
module tb_board_snapshot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        load_en;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic [5:0]  cell_sel;
  logic [1:0]  cell_state;
  logic        busy;
  logic        frame_done;
  logic        bad_cell;

  board_snapshot_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .load_en(load_en),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .cell_sel(cell_sel),
    .cell_state(cell_state),
    .busy(busy),
    .frame_done(frame_done),
    .bad_cell(bad_cell)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];

  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem[mem_addr] : 16'hdead;
  end

  typedef struct {
    logic [5:0] sel;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [9];

  int total = 0;
  int passed = 0;

  logic [1:0] disp_m [42];
  logic       bad_m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] wmap(input logic [15:0] w);
    if (w == 16'd0) return 2'b00;
    if (w == 16'd1) return 2'b01;
    if (w == 16'd2) return 2'b10;
    return 2'b11;
  endfunction

  task automatic chk_disp(input string name);
    int errs = 0;
    for (int i = 0; i < 42; i++) begin
      cell_sel = 6'(i);
      #1;
      if (cell_state !== disp_m[i]) errs++;
    end
    chk(name, errs, 0);
  endtask

  task automatic snapshot(input int fall2, input int rst_at,
                          input bit drop_le);
    logic [1:0] nd [42];
    logic nb = 1'b0;
    int fd_cycle = -1;
    int fd_cnt = 0;
    int falls = 0;
    int errs_a = 0;
    int errs_b = 0;
    int errs_s = 0;
    int cnt = 0;
    logic pb;
    logic [11:0] ea;
    for (int i = 0; i < 42; i++) begin
      nd[i] = wmap(mem[2048 + i]);
      if (nd[i] == 2'b11) nb = 1'b1;
    end
    pb = busy;
    vsync = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (rst_at != 0 && n == rst_at) begin
        chk("pre_reset_addr", mem_addr, 12'h800 + 12'(n - 1));
        rst_n = 1'b0;
        #1;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 12'h800);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_bad_cell", bad_cell, 0);
        for (int i = 0; i < 42; i++) disp_m[i] = 2'b00;
        bad_m = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 60; j++) begin
          tick();
          if (frame_done || busy) cnt++;
        end
        chk("rst_no_frame", cnt, 0);
        chk_disp("rst_display_zero");
        return;
      end
      ea = (n <= 42) ? 12'h800 + 12'(n - 1) : 12'h800;
      if (mem_rd_en !== (n <= 42) || mem_addr !== ea) errs_a++;
      if (busy !== (n <= 44)) errs_b++;
      if (frame_done) begin
        fd_cnt++;
        fd_cycle = n;
        for (int i = 0; i < 42; i++) disp_m[i] = nd[i];
      end
      if (pb && !busy) falls++;
      pb = busy;
      if (n == 3) vsync = 1'b1;
      if (n == fall2) vsync = 1'b0;
      if (fall2 != 0 && n == fall2 + 2) vsync = 1'b1;
      if (drop_le && n == 10) load_en = 1'b0;
      if (drop_le && n == 50) load_en = 1'b1;
      cell_sel = 6'((n - 1) % 42);
      #1;
      if (cell_state !== disp_m[(n - 1) % 42]) errs_s++;
    end
    bad_m = bad_m | nb;
    chk("fetch_addr_seq", errs_a, 0);
    chk("busy_window", errs_b, 0);
    chk("sweep_display", errs_s, 0);
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_latency", fd_cycle - 1, 44);
    chk("busy_falls", falls, 1);
    chk("bad_cell", bad_cell, bad_m);
    chk_disp("display_after_frame");
  endtask

  initial begin
    int cnt;
    vecs[0] = '{6'd0,  2'b00};
    vecs[1] = '{6'd1,  2'b01};
    vecs[2] = '{6'd2,  2'b10};
    vecs[3] = '{6'd5,  2'b10};
    vecs[4] = '{6'd6,  2'b00};
    vecs[5] = '{6'd40, 2'b01};
    vecs[6] = '{6'd41, 2'b10};
    vecs[7] = '{6'd42, 2'b00};
    vecs[8] = '{6'd63, 2'b00};

    for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
    for (int i = 0; i < 42; i++) disp_m[i] = 2'b00;
    bad_m = 1'b0;
    rst_n = 1'b0;
    vsync = 1'b1;
    load_en = 1'b1;
    cell_sel = 6'd0;
    #12;
    chk("reset_rd_en", mem_rd_en, 0);
    chk("reset_addr", mem_addr, 12'h800);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_bad_cell", bad_cell, 0);
    chk_disp("reset_display");
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 42; i++) mem[2048 + i] = 16'(i % 3);
    snapshot(0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cell_sel = vecs[i].sel;
      #1;
      chk($sformatf("table_sel_%0d", vecs[i].sel), cell_state, vecs[i].exp);
    end

    for (int i = 0; i < 42; i++) mem[2048 + i] = 16'((i + 1) % 3);
    snapshot(20, 0, 1'b1);
    tick();
    tick();
    chk("no_queued_trigger", busy, 0);

    mem[2050] = 16'h0007;
    snapshot(0, 0, 1'b0);
    cell_sel = 6'd2;
    #1;
    chk("bad_word_cell", cell_state, 2'b11);
    chk("bad_flag_set", bad_cell, 1);
    mem[2050] = 16'd2;
    snapshot(0, 0, 1'b0);
    chk("bad_flag_sticky", bad_cell, 1);

    load_en = 1'b0;
    vsync = 1'b0;
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (mem_rd_en || busy) cnt++;
    end
    chk("load_en_block", cnt, 0);
    chk_disp("load_en_display_kept");
    cell_sel = 6'd63;
    #1;
    chk("sel_63", cell_state, 2'b00);
    vsync = 1'b1;
    tick();
    load_en = 1'b1;
    tick();

    snapshot(0, 31, 1'b0);

    vsync = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (mem_rd_en || busy) cnt++;
    end
    chk("low_vsync_no_start", cnt, 0);
    vsync = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 42; i++) mem[2048 + i] = 16'(i % 3);
    snapshot(0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cell_sel = vecs[i].sel;
      #1;
      chk($sformatf("table2_sel_%0d", vecs[i].sel), cell_state, vecs[i].exp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
